// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Ports: clk, rst (sync, active-high); start_i/signed_i/annul_i control;
// dividend_i/divisor_i operands; result_o {remainder, quotient}; ready_o
// one-cycle done pulse; stallreq_for_ex pipeline stall request.
// Optional: define DIV_ZERO_FLAG_EN to add div_by_zero_o (high with ready_o
// when the divisor was zero).
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                signed_i,
  input  logic                annul_i,
  input  logic [DATA_W-1:0]   dividend_i,
  input  logic [DATA_W-1:0]   divisor_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_for_ex
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic                div_by_zero_o
`endif
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, DIV_ZERO, ON, END} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] rem, dvd, dsr, rem_n, quo_n, abs_a, abs_b;
  logic [DATA_W:0] diff;
  logic neg_q, neg_r, last;
  assign stallreq_for_ex = start_i & ~ready_o;
  assign last = cnt == CW'(DATA_W - 1);
  assign abs_a = (signed_i & dividend_i[DATA_W-1]) ? -dividend_i : dividend_i;
  assign abs_b = (signed_i & divisor_i[DATA_W-1]) ? -divisor_i : divisor_i;
  // Trial subtraction on the shifted partial remainder; the borrow bit
  // decides both the restore and the new quotient bit.
  assign diff = {rem, dvd[DATA_W-1]} - {1'b0, dsr};
  assign rem_n = diff[DATA_W] ? {rem[DATA_W-2:0], dvd[DATA_W-1]} : diff[DATA_W-1:0];
  assign quo_n = {dvd[DATA_W-2:0], ~diff[DATA_W]};
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    nxt = annul_i              ? IDLE :
          state == IDLE        ? (start_i ? (divisor_i == '0 ? DIV_ZERO : ON) : IDLE) :
          state == DIV_ZERO    ? END :
          state == ON          ? (last ? END : ON) : IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      cnt      <= '0;
      rem      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      div_by_zero_o <= 1'b0;
`endif
    end else begin
      ready_o <= nxt == END;
`ifdef DIV_ZERO_FLAG_EN
      div_by_zero_o <= nxt == END && state == DIV_ZERO;
`endif
      if (state == IDLE && start_i && !annul_i) begin
        cnt   <= '0;
        rem   <= '0;
        dvd   <= abs_a;
        dsr   <= abs_b;
        neg_q <= signed_i & (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
        neg_r <= signed_i & dividend_i[DATA_W-1];
      end
      if (state == ON && !annul_i) begin
        rem <= rem_n;
        dvd <= quo_n;
        cnt <= cnt + 1'b1;
      end
      // Result is captured with the sign fix-up on the edge entering END.
      if (nxt == END)
        result_o <= state == DIV_ZERO ? '0 : {neg_r ? -rem_n : rem_n, neg_q ? -quo_n : quo_n};
    end
endmodule
